// File: rtl/result_demux.sv
// Routes one producer result stream to one of 2^SEL_W consumers through a two-entry elastic buffer.
// Latency 1 cycle; in_ready is registered and falls only when both head and skid are occupied.
module result_demux #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [SEL_W-1:0]         in_sel,
  output logic [(1<<SEL_W)-1:0]    out_valid,
  input  logic [(1<<SEL_W)-1:0]    out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     busy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   head_data;
  logic [SEL_W-1:0]   head_sel;
  logic [WIDTH-1:0]   skid_data;
  logic [SEL_W-1:0]   skid_sel;
  logic               push;
  logic               pop;
  logic               ld_head_in;
  logic               ld_head_skid;
  logic               ld_skid;

  assign push = in_valid & in_ready;
  // Only the head destination's ready matters; others are ignored (head-of-line blocking).
  assign pop  = (state != EMPTY) & out_ready[head_sel];

  always_comb begin
    state_nxt    = state;
    ld_head_in   = 1'b0;
    ld_head_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            ld_head_in = 1'b1;
            state_nxt  = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            ld_head_in = 1'b1;
          end else if (push) begin
            ld_skid   = 1'b1;
            state_nxt = TWO;
          end else if (pop) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            ld_head_skid = 1'b1;
            state_nxt    = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      head_data <= '0;
      head_sel  <= '0;
      skid_data <= '0;
      skid_sel  <= '0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != TWO);
      if (ld_head_in) begin
        head_data <= in_data;
        head_sel  <= in_sel;
      end else if (ld_head_skid) begin
        head_data <= skid_data;
        head_sel  <= skid_sel;
      end
      if (ld_skid) begin
        skid_data <= in_data;
        skid_sel  <= in_sel;
      end
    end
  end

  // Decoded from registered state only, so reset clears it asynchronously without glitches.
  always_comb begin
    out_valid = '0;
    if (state != EMPTY) begin
      out_valid[head_sel] = 1'b1;
    end
  end

  assign out_data = head_data;
  assign busy     = (state != EMPTY);

endmodule

// File: tb/tb_result_demux.sv
// Randomized and directed bench for result_demux against a queue-based reference model.
module tb_result_demux;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;
  logic        busy;

  logic        flush8;
  logic        in_valid8;
  logic        in_ready8;
  logic [7:0]  in_data8;
  logic [2:0]  in_sel8;
  logic [7:0]  out_valid8;
  logic [7:0]  out_ready8;
  logic [7:0]  out_data8;
  logic        busy8;

  int checks;
  int failures;

  logic [31:0] qd[$];
  logic [1:0]  qs[$];
  logic [31:0] last_d;

  result_demux #(.WIDTH(32), .SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  result_demux #(.WIDTH(8), .SEL_W(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush8),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .in_sel(in_sel8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8), .busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {out_valid, out_data, in_ready, busy} from the current queue contents.
  function automatic logic [37:0] exp_vec();
    logic [3:0] v;
    v = 4'b0;
    if (qd.size() > 0) v = 4'b1 << qs[0];
    return {v, last_d, (qd.size() < 2), (qd.size() != 0)};
  endfunction

  // Applies the current inputs at the coming clock edge to the queue model.
  task automatic model_edge();
    int sz;
    sz = qd.size();
    if (flush) begin
      qd.delete();
      qs.delete();
    end else begin
      if (sz > 0 && out_ready[qs[0]]) begin
        void'(qd.pop_front());
        void'(qs.pop_front());
      end
      if (in_valid && sz < 2) begin
        qd.push_back(in_data);
        qs.push_back(in_sel);
      end
    end
    if (qd.size() > 0) last_d = qd[0];
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [1:0] s,
                       input logic [3:0] rdy, input logic fl);
    in_valid  = v;
    in_data   = d;
    in_sel    = s;
    out_ready = rdy;
    flush     = fl;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hC0 + i, i[1:0], 4'b0, 1'b0);
      @(negedge clk);
      checks++;
      if ({out_valid, out_data, in_ready, busy} !== exp_vec()) begin
        failures++;
        $display("FAIL reset_fill cyc=%0d obs=%h exp=%h", i, {out_valid, out_data, in_ready, busy}, exp_vec());
      end
      model_edge();
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    qd.delete(); qs.delete(); last_d = 32'h0;
    checks++;
    if ({out_valid, in_ready, busy} !== {4'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_async obs=%b req=%b", {out_valid, in_ready, busy}, 6'b000010);
    end
    drive(1'b0, 32'h0, 2'd0, 4'hF, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_data, in_ready, busy} !== exp_vec()) begin
        failures++;
        $display("FAIL reset_after cyc=%0d obs=%h exp=%h", i, {out_valid, out_data, in_ready, busy}, exp_vec());
      end
      model_edge();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(1'b1, 32'hA0 + i, i[1:0], 4'hF, 1'b0);
      else       drive(1'b0, 32'h0, 2'd0, 4'hF, 1'b0);
      @(negedge clk);
      checks++;
      if ({out_valid, out_data, in_ready, busy} !== exp_vec()) begin
        failures++;
        $display("FAIL stream cyc=%0d obs=%h exp=%h", i, {out_valid, out_data, in_ready, busy}, exp_vec());
      end
      if (i >= 1 && i <= 8) begin
        checks++;
        if (out_valid !== (4'b1 << ((i - 1) % 4)) || out_data !== 32'hA0 + i - 1 || in_ready !== 1'b1) begin
          failures++;
          $display("FAIL stream_seq cyc=%0d valid=%b data=%h rdy=%b", i, out_valid, out_data, in_ready);
        end
      end
      model_edge();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] td[9];
    logic [1:0]  ts[9];
    logic        tv[9];
    logic [3:0]  tr[9];
    td = '{32'h11, 32'h22, 32'h33, 32'h33, 32'h33, 32'h33, 32'h33, 32'h0, 32'h0};
    ts = '{2'd2, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
    tv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tr = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0100, 4'b0101, 4'b1111, 4'b0000};
    for (int i = 0; i < 9; i++) begin
      drive(tv[i], td[i], ts[i], tr[i], 1'b0);
      @(negedge clk);
      checks++;
      if ({out_valid, out_data, in_ready, busy} !== exp_vec()) begin
        failures++;
        $display("FAIL backpressure cyc=%0d obs=%h exp=%h", i, {out_valid, out_data, in_ready, busy}, exp_vec());
      end
      if (i == 4) begin
        checks++;
        if (out_valid !== 4'b0100 || out_data !== 32'h11 || in_ready !== 1'b0) begin
          failures++;
          $display("FAIL hol_block valid=%b data=%h rdy=%b req=0100/11/0", out_valid, out_data, in_ready);
        end
      end
      model_edge();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_push_pop();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       drive(1'b1, 32'h55, 2'd1, 4'b0000, 1'b0);
        1:       drive(1'b1, 32'h66, 2'd3, 4'b0010, 1'b0);
        2:       drive(1'b0, 32'h0, 2'd0, 4'b0000, 1'b0);
        default: drive(1'b0, 32'h0, 2'd0, 4'b1000, 1'b0);
      endcase
      @(negedge clk);
      checks++;
      if ({out_valid, out_data, in_ready, busy} !== exp_vec()) begin
        failures++;
        $display("FAIL push_pop cyc=%0d obs=%h exp=%h", i, {out_valid, out_data, in_ready, busy}, exp_vec());
      end
      if (i == 2) begin
        checks++;
        if (out_valid !== 4'b1000 || out_data !== 32'h66 || in_ready !== 1'b1) begin
          failures++;
          $display("FAIL push_pop_one valid=%b data=%h rdy=%b req=1000/66/1", out_valid, out_data, in_ready);
        end
      end
      model_edge();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:       drive(1'b1, 32'h101, 2'd1, 4'b0000, 1'b0);
        1:       drive(1'b1, 32'h202, 2'd2, 4'b0000, 1'b0);
        2:       drive(1'b1, 32'h303, 2'd3, 4'b1111, 1'b1);
        default: drive(1'b0, 32'h0, 2'd0, 4'b1111, 1'b0);
      endcase
      @(negedge clk);
      checks++;
      if ({out_valid, out_data, in_ready, busy} !== exp_vec()) begin
        failures++;
        $display("FAIL flush cyc=%0d obs=%h exp=%h", i, {out_valid, out_data, in_ready, busy}, exp_vec());
      end
      if (i == 3) begin
        checks++;
        if (out_valid !== 4'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
          failures++;
          $display("FAIL flush_empty valid=%b busy=%b rdy=%b req=0000/0/1", out_valid, busy, in_ready);
        end
      end
      model_edge();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), $urandom, 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)), ($urandom_range(0, 29) == 0));
      @(negedge clk);
      checks++;
      if ({out_valid, out_data, in_ready, busy} !== exp_vec()) begin
        failures++;
        $display("FAIL random cyc=%0d obs=%h exp=%h", i, {out_valid, out_data, in_ready, busy}, exp_vec());
      end
      model_edge();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_param_sweep();
    in_valid8  = 1'b1;
    in_data8   = 8'hFF;
    in_sel8    = 3'd7;
    out_ready8 = 8'h00;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid8 !== 8'h80 || out_data8 !== 8'hFF || busy8 !== 1'b1) begin
      failures++;
      $display("FAIL sweep_sel7 valid=%h data=%h busy=%b req=80/FF/1", out_valid8, out_data8, busy8);
    end
    out_ready8 = 8'h80;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (out_valid8 !== 8'h00 || busy8 !== 1'b0) begin
      failures++;
      $display("FAIL sweep_drain valid=%h busy=%b req=00/0", out_valid8, busy8);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    last_d = 32'h0;
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 2'd0, 4'h0, 1'b0);
    flush8 = 1'b0; in_valid8 = 1'b0; in_data8 = 8'h0; in_sel8 = 3'd0; out_ready8 = 8'h0;
    @(negedge clk);
    checks++;
    if ({out_valid, out_data, in_ready, busy} !== {4'b0, 32'h0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_state obs=%h req=%h", {out_valid, out_data, in_ready, busy}, {4'b0, 32'h0, 1'b1, 1'b0});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_streaming();
    test_backpressure();
    test_push_pop();
    test_flush();
    test_reset();
    test_random();
    test_param_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
